// File: rtl/mips_regfile_pkg.sv
// Shared constants and types for the MIPS register-file read side.
package mips_regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  function automatic logic [NUM_REGS-1:0] addrOneHot(input reg_addr_t addr);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// BYPASS lets a same-cycle writeback mask the pending bit it is about to clear.
module reg_scoreboard
  import mips_regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              setEn,
  input  logic [ADDR_W-1:0] setAddr,
  input  logic              clrEn,
  input  logic [ADDR_W-1:0] clrAddr,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rsBusy,
  output logic              rtBusy,
  output logic              rdBusy,
  output logic              rsClr,
  output logic              rtClr
);
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;
  logic [NUM_REGS-1:0] pendingNext;
  logic                clrValid;
  logic                rdClr;

  assign clrValid = clrEn && (clrAddr != ZERO_REG);
  assign setMask  = (setEn && (setAddr != ZERO_REG)) ? addrOneHot(setAddr) : '0;
  assign clrMask  = clrValid ? addrOneHot(clrAddr) : '0;

  // Set is applied after clear so a same-cycle set of the same bit wins.
  always_comb begin
    pendingNext    = (pending & ~clrMask) | setMask;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pending <= '0;
    else          pending <= pendingNext;
  end

  assign rsClr = BYPASS && clrValid && (clrAddr == rsAddr);
  assign rtClr = BYPASS && clrValid && (clrAddr == rtAddr);
  assign rdClr = BYPASS && clrValid && (clrAddr == rdAddr);

  assign rsBusy = (rsAddr != ZERO_REG) && pending[rsAddr] && !rsClr;
  assign rtBusy = (rtAddr != ZERO_REG) && pending[rtAddr] && !rtClr;
  assign rdBusy = (rdAddr != ZERO_REG) && pending[rdAddr] && !rdClr;
endmodule

// File: rtl/regfile_reader.sv
// Decode-stage register read with pending-write stall and registered operand output.
// Define REGFILE_READER_BYPASS_EN to forward same-cycle writeback data instead of stalling.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends on ready, and data holds while valid is high and ready is low.
module regfile_reader
  import mips_regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_we,
  output logic [ADDR_W-1:0] o_rs_raddr,
  output logic [ADDR_W-1:0] o_rt_raddr,
  input  logic [DATA_W-1:0] i_rs_rdata,
  input  logic [DATA_W-1:0] i_rt_rdata,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_we
);
`ifdef REGFILE_READER_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic      rsBusy, rtBusy, rdBusy;
  logic      rsClr, rtClr;
  logic      hazard;
  logic      accept;
  reg_data_t rsOperand, rtOperand;

  assign o_rs_raddr = i_rs_addr;
  assign o_rt_raddr = i_rt_addr;

  reg_scoreboard #(.BYPASS(BypassEn)) uScoreboard (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .setEn   (accept && i_rd_we),
    .setAddr (i_rd_addr),
    .clrEn   (i_wb_en),
    .clrAddr (i_wb_addr),
    .rsAddr  (i_rs_addr),
    .rtAddr  (i_rt_addr),
    .rdAddr  (i_rd_addr),
    .rsBusy  (rsBusy),
    .rtBusy  (rtBusy),
    .rdBusy  (rdBusy),
    .rsClr   (rsClr),
    .rtClr   (rtClr)
  );

  assign hazard      = rsBusy || rtBusy || (i_rd_we && rdBusy);
  assign o_req_ready = !hazard && (!o_out_valid || i_out_ready);
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    rsOperand = i_rs_rdata;
    rtOperand = i_rt_rdata;
    if (i_rs_addr == ZERO_REG) rsOperand = '0;
    else if (rsClr)            rsOperand = i_wb_data;
    if (i_rt_addr == ZERO_REG) rtOperand = '0;
    else if (rtClr)            rtOperand = i_wb_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid <= 1'b0;
      o_rs_data   <= '0;
      o_rt_data   <= '0;
      o_rd_addr   <= '0;
      o_rd_we     <= 1'b0;
    end else if (accept) begin
      o_out_valid <= 1'b1;
      o_rs_data   <= rsOperand;
      o_rt_data   <= rtOperand;
      o_rd_addr   <= i_rd_addr;
      o_rd_we     <= i_rd_we;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader with a behavioural register array model.
module tb_regfile_reader;
  import mips_regfile_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_rs_addr, i_rt_addr, i_rd_addr;
  logic              i_rd_we;
  logic [ADDR_W-1:0] o_rs_raddr, o_rt_raddr;
  logic [DATA_W-1:0] i_rs_rdata, i_rt_rdata;
  logic              i_wb_en;
  logic [ADDR_W-1:0] i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [DATA_W-1:0] o_rs_data, o_rt_data;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_rd_we;

  logic [DATA_W-1:0] regs [NUM_REGS];
  int errCount = 0;
  int checkCount = 0;

  always #5 i_clk = ~i_clk;

  regfile_reader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we),
    .o_rs_raddr(o_rs_raddr), .o_rt_raddr(o_rt_raddr),
    .i_rs_rdata(i_rs_rdata), .i_rt_rdata(i_rt_rdata),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we)
  );

  // Array model: combinational read, write at the writeback edge, $zero never written.
  assign i_rs_rdata = regs[o_rs_raddr];
  assign i_rt_rdata = regs[o_rt_raddr];
  always @(posedge i_clk)
    if (i_wb_en && i_wb_addr != ZERO_REG) regs[i_wb_addr] <= i_wb_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic req(input logic v, input int rs, input int rt, input int rd, input logic we);
    i_req_valid = v;
    i_rs_addr = ADDR_W'(rs);
    i_rt_addr = ADDR_W'(rt);
    i_rd_addr = ADDR_W'(rd);
    i_rd_we = we;
  endtask

  task automatic wb(input logic en, input int addr, input logic [31:0] data);
    i_wb_en = en;
    i_wb_addr = ADDR_W'(addr);
    i_wb_data = data;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000 + i;
    regs[0] = 32'hFFFF_FFFF;
    regs[1] = 32'h11;
    regs[2] = 32'h22;
    i_rst_n = 1'b0;
    req(1'b0, 0, 0, 0, 1'b0);
    wb(1'b0, 0, 0);
    i_out_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_valid", 32'(o_out_valid), 0);
    check("rst_rs", o_rs_data, 0);
    check("rst_rt", o_rt_data, 0);
    check("rst_rd", {o_rd_we, o_rd_addr}, 0);
    check("rst_pending", dut.uScoreboard.pending, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // First request: rs=1 rt=2 rd=3
    req(1'b1, 1, 2, 3, 1'b1);
    #1 check("req1_ready", 32'(o_req_ready), 1);
    check("raddr", {o_rs_raddr, o_rt_raddr}, {5'd1, 5'd2});
    step();
    check("req1_valid", 32'(o_out_valid), 1);
    check("req1_rs", o_rs_data, 32'h11);
    check("req1_rt", o_rt_data, 32'h22);
    check("req1_rd", {o_rd_we, o_rd_addr}, {1'b1, 5'd3});
    check("req1_pending", dut.uScoreboard.pending, 32'h8);

    // RAW on r3
    req(1'b1, 3, 0, 0, 1'b0);
    #1 check("raw_stall0", 32'(o_req_ready), 0);
    step();
    check("raw_drained", 32'(o_out_valid), 0);
    check("raw_stall1", 32'(o_req_ready), 0);
    wb(1'b1, 3, 32'hAB);
`ifdef REGFILE_READER_BYPASS_EN
    #1 check("raw_bypass_ready", 32'(o_req_ready), 1);
    step();
    wb(1'b0, 0, 0);
`else
    #1 check("raw_wb_ready", 32'(o_req_ready), 0);
    step();
    wb(1'b0, 0, 0);
    check("raw_wb_valid", 32'(o_out_valid), 0);
    #1 check("raw_next_ready", 32'(o_req_ready), 1);
    step();
`endif
    check("raw_valid", 32'(o_out_valid), 1);
    check("raw_rs", o_rs_data, 32'hAB);
    check("raw_pending", dut.uScoreboard.pending, 0);

    // WAW on r3
    req(1'b1, 1, 2, 3, 1'b1);
    step();
    check("waw_first_pending", dut.uScoreboard.pending, 32'h8);
    #1 check("waw_stall", 32'(o_req_ready), 0);
    wb(1'b1, 3, 32'h55);
`ifdef REGFILE_READER_BYPASS_EN
    #1 check("waw_bypass_ready", 32'(o_req_ready), 1);
    step();
    wb(1'b0, 0, 0);
`else
    #1 check("waw_wb_ready", 32'(o_req_ready), 0);
    step();
    wb(1'b0, 0, 0);
    #1 check("waw_next_ready", 32'(o_req_ready), 1);
    step();
`endif
    check("waw_rs", o_rs_data, 32'h11);
    check("waw_pending", dut.uScoreboard.pending, 32'h8);

    // $zero source and writeback to $zero
    req(1'b1, 0, 2, 0, 1'b1);
    wb(1'b1, 0, 32'h5);
    #1 check("zero_ready", 32'(o_req_ready), 1);
    step();
    wb(1'b0, 0, 0);
    check("zero_rs", o_rs_data, 0);
    check("zero_rt", o_rt_data, 32'h22);
    check("zero_pending", dut.uScoreboard.pending, 32'h8);

    // Backpressure for three cycles
    i_out_ready = 1'b0;
    req(1'b1, 1, 2, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", 32'(o_req_ready), 0);
      step();
      check("bp_valid", 32'(o_out_valid), 1);
      check("bp_rs_hold", o_rs_data, 0);
      check("bp_rd_hold", {o_rd_we, o_rd_addr}, {1'b1, 5'd0});
    end
    i_out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(o_req_ready), 1);
    step();
    check("bp_rs", o_rs_data, 32'h11);
    check("bp_rd", {o_rd_we, o_rd_addr}, {1'b0, 5'd4});

    // Retire r3, then rebuild a stall and reset in the middle of it
    req(1'b0, 0, 0, 0, 1'b0);
    wb(1'b1, 3, 32'h55);
    step();
    wb(1'b0, 0, 0);
    check("retire_pending", dut.uScoreboard.pending, 0);
    req(1'b1, 1, 2, 3, 1'b1);
    step();
    req(1'b1, 3, 0, 0, 1'b0);
    #1 check("mid_stall", 32'(o_req_ready), 0);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_valid", 32'(o_out_valid), 0);
    check("async_pending", dut.uScoreboard.pending, 0);
    check("async_rs", o_rs_data, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(o_req_ready), 1);
    step();
    check("post_rst_valid", 32'(o_out_valid), 1);
    check("post_rst_rs", o_rs_data, 32'h55);

    // Back-to-back throughput
    for (int i = 0; i < 3; i++) begin
      req(1'b1, i + 5, i + 6, 0, 1'b0);
      #1 check("tput_ready", 32'(o_req_ready), 1);
      step();
      check("tput_rs", o_rs_data, 32'h1000 + i + 5);
      check("tput_rt", o_rt_data, 32'h1000 + i + 6);
    end
    req(1'b0, 0, 0, 0, 1'b0);
    step();
    check("idle_valid", 32'(o_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule

// File: doc/regfile_reader.md
# regfile_reader

Decode-stage read side of the pipelined MIPS register file: accepts one instruction's operand request per cycle, reads rs/rt from the register array, and hands registered operands to the execute stage over a valid/ready handshake. A 32-entry pending-write scoreboard stalls requests whose operands or destination have an outstanding write. The scoreboard clears when the writeback port (the array's write side) retires that register.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers; address 0 is $zero)

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  operand request present
- o_req_ready  out  1  request accepted this cycle when high with i_req_valid
- i_rs_addr, i_rt_addr  in  ADDR_W  source register addresses
- i_rd_addr  in  ADDR_W  destination register of the requesting instruction
- i_rd_we  in  1  requesting instruction will write i_rd_addr
- o_rs_raddr, o_rt_raddr  out  ADDR_W  read addresses to array (combinational copies of i_rs_addr/i_rt_addr)
- i_rs_rdata, i_rt_rdata  in  DATA_W  combinational array read data
- i_wb_en  in  1  writeback strobe (array is written at the same edge)
- i_wb_addr  in  ADDR_W  writeback register
- i_wb_data  in  DATA_W  writeback data
- o_out_valid  out  1  operands valid to execute
- i_out_ready  in  1  execute accepts operands
- o_rs_data, o_rt_data  out  DATA_W  operand values
- o_rd_addr  out  ADDR_W, o_rd_we  out  1  destination info forwarded with operands

## Operation
- pending[31:0] scoreboard; pending[0] is constant 0.
- hazard = (rs≠0 & pending[rs] & !clr_rs) | (rt≠0 & pending[rt] & !clr_rt) | (i_rd_we & rd≠0 & pending[rd] & !clr_rd), where clr_x = bypass-enabled match of i_wb_en & i_wb_addr==x.
- o_req_ready = !hazard & (!o_out_valid | i_out_ready).
- Accept (i_req_valid & o_req_ready): capture operands into output register; o_rs_data = 0 if rs==0, else i_wb_data if clr_rs, else i_rs_rdata; rt likewise. Set pending[rd] if i_rd_we & rd≠0.
- i_wb_en with i_wb_addr≠0: clear pending[i_wb_addr]. Same-cycle set and clear of one bit: set wins.
- Writeback to address 0 ignored; i_wb_en to a non-pending register only clears (no error).
- Output stage: o_out_valid set on accept; cleared when i_out_ready & no new accept; holds data while o_out_valid & !i_out_ready.

## Timing
- Reset: o_out_valid=0, o_rs_data=o_rt_data=0, o_rd_addr=0, o_rd_we=0, pending=0; effective immediately on i_rst_n low, asynchronously.
- Latency: accept at edge N → o_out_valid high after edge N.
- Throughput: one request per cycle with no hazards and i_out_ready held high.
- Reset mid-operation drops the held output and all pending bits; no replay.
- o_req_ready depends combinationally on i_wb_*, i_out_ready and request addresses; i_req_valid must not depend on o_req_ready.

## Configuration
- REGFILE_READER_BYPASS_EN defined: clr_x as above; a request reading the register being written back in the same cycle is accepted with i_wb_data.
- Undefined: clr_x forced 0; such a request stalls one cycle and reads the updated array value next cycle.

## Structure
- Package mips_regfile_pkg: DATA_W, ADDR_W, NUM_REGS=32, ZERO_REG=0 constants, reg_addr_t/reg_data_t typedefs.
- Sub-module reg_scoreboard: pending vector, set/clear ports, per-address lookup with clear masking.

## Test plan
- Reset then request rs=1, rt=2, array 0x11/0x22, rd=3 we=1 → next cycle o_out_valid=1, o_rs_data=0x11, o_rt_data=0x22; pending[3]=1.
- Follow with request rs=3 → o_req_ready=0 until i_wb_en addr=3 data=0xAB; with BYPASS_EN accepted that cycle, o_rs_data=0xAB; without, accepted one cycle later.
- Request rd=3 we=1 while pending[3]=1 → stalled (WAW); accepted when writeback of 3 arrives.
- rs=0 with array returning 0xFFFFFFFF and wb to addr 0 data 0x5 → o_rs_data=0, pending unchanged.
- i_out_ready=0 for 3 cycles with o_out_valid=1 → outputs stable, o_req_ready=0; release → next request accepted same cycle.
- Drive i_rst_n low mid-stall with pending[3]=1 → o_out_valid=0 and pending cleared immediately; request rs=3 accepted after release.
